// File: rtl/nand_serial_lu.sv
// Bit-serial logic unit: every result bit is built only from 2-input NAND gates, one bit per cycle, LSB first.
// Optional zero/parity result flags are enabled by defining NAND_LU_FLAGS_EN.
module nand_serial_lu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s
`ifdef NAND_LU_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             done_q, done_d;
`ifdef NAND_LU_FLAGS_EN
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
`endif

  logic             bit_res;

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  // Every operation is a small network of nand2 gates; the select only picks the network.
  function automatic logic nand_op(input logic [2:0] sel, input logic x, input logic y);
    logic nxy, nxx, nyy, t, r;
    nxy = nand2(x, y);
    nxx = nand2(x, x);
    nyy = nand2(y, y);
    t   = 1'b0;
    r   = 1'b0;
    case (sel)
      3'd0: r = nand2(nxy, nxy);
      3'd1: r = nand2(nxx, nyy);
      3'd2: r = nxy;
      3'd3: begin
        t = nand2(nxx, nyy);
        r = nand2(t, t);
      end
      3'd4: r = nand2(nand2(x, nxy), nand2(y, nxy));
      3'd5: begin
        t = nand2(nand2(x, nxy), nand2(y, nxy));
        r = nand2(t, t);
      end
      3'd6: r = nxx;
      default: r = nand2(nxx, nxx);
    endcase
    return r;
  endfunction

  assign bit_res = nand_op(op_q, a_q[idx_q], b_q[idx_q]);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    done_d  = 1'b0;
`ifdef NAND_LU_FLAGS_EN
    zero_d   = zero_q;
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[idx_q] = bit_res;
        idx_d        = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // The result register is only exposed here, so s never shows a partial value.
        s_d     = res_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef NAND_LU_FLAGS_EN
        zero_d   = (res_q == '0);
        parity_d = ^res_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
`ifdef NAND_LU_FLAGS_EN
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      done_q  <= done_d;
`ifdef NAND_LU_FLAGS_EN
      zero_q   <= zero_d;
      parity_q <= parity_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign s    = s_q;
`ifdef NAND_LU_FLAGS_EN
  assign zero   = zero_q;
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_nand_serial_lu.sv
// Self-checking bench for nand_serial_lu: an 8-bit and a 16-bit instance share clock and reset.
// Table vectors, random operations against a bitwise model, and hand sequences for back-to-back and reset cases.
module tb_nand_serial_lu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start16;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        busy8, done8, busy16, done16;
  logic [7:0]  s8;
  logic [15:0] s16;
`ifdef NAND_LU_FLAGS_EN
  logic        zero8, parity8, zero16, parity16;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  nand_serial_lu #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .op    (op),
    .a     (a[7:0]),
    .b     (b[7:0]),
    .busy  (busy8),
    .done  (done8),
    .s     (s8)
`ifdef NAND_LU_FLAGS_EN
    ,
    .zero  (zero8),
    .parity(parity8)
`endif
  );

  nand_serial_lu #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .start (start16),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy16),
    .done  (done16),
    .s     (s16)
`ifdef NAND_LU_FLAGS_EN
    ,
    .zero  (zero16),
    .parity(parity16)
`endif
  );

  typedef struct {
    bit          w16;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_s;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain bitwise operators, truncated to the instance width.
  function automatic logic [15:0] ref_op(input logic [2:0] o, input logic [15:0] x,
                                         input logic [15:0] y, input bit w16);
    logic [15:0] r;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = ~(x & y);
      3'd3: r = ~(x | y);
      3'd4: r = x ^ y;
      3'd5: r = ~(x ^ y);
      3'd6: r = ~x;
      default: r = x;
    endcase
    return w16 ? r : (r & 16'h00FF);
  endfunction

  function automatic logic [15:0] cur_s(input bit w16);
    return w16 ? s16 : {8'h00, s8};
  endfunction

  function automatic logic cur_done(input bit w16);
    return w16 ? done16 : done8;
  endfunction

  function automatic logic cur_busy(input bit w16);
    return w16 ? busy16 : busy8;
  endfunction

  task automatic set_start(input bit w16, input logic v);
    if (w16) start16 = v;
    else     start8  = v;
  endtask

  // One operation; operands, op and start are scrambled while busy to show they are ignored.
  task automatic run_op(input bit w16, input logic [2:0] op_v, input logic [15:0] a_v,
                        input logic [15:0] b_v, input logic [15:0] exp_s, input string tag);
    int          w, c, busy_n;
    bit          seen, partial;
    logic [15:0] s_prev;
    w = w16 ? 16 : 8;
    @(negedge clk);
    s_prev = cur_s(w16);
    op = op_v;
    a  = a_v;
    b  = b_v;
    set_start(w16, 1'b1);
    @(posedge clk);
    @(negedge clk);
    c = 0; busy_n = 0; seen = 1'b0; partial = 1'b0;
    while (!seen && c <= 3 * w) begin
      if (cur_done(w16)) begin
        seen = 1'b1;
        set_start(w16, 1'b0);
      end else begin
        if (cur_busy(w16)) busy_n++;
        if (cur_s(w16) !== s_prev) partial = 1'b1;
        op = 3'($urandom);
        a  = 16'($urandom);
        b  = 16'($urandom);
        set_start(w16, 1'($urandom_range(0, 1)));
        @(posedge clk);
        @(negedge clk);
        c++;
      end
    end
    set_start(w16, 1'b0);
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(c), 32'(w + 1));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(w + 1));
    check({tag, " s_held_while_busy"}, 32'(partial), 32'd0);
    check({tag, " s"}, 32'(cur_s(w16)), 32'(exp_s));
    check({tag, " busy_at_done"}, 32'(cur_busy(w16)), 32'd0);
`ifdef NAND_LU_FLAGS_EN
    check({tag, " zero"}, 32'(w16 ? zero16 : zero8), 32'(exp_s == 16'h0000));
    check({tag, " parity"}, 32'(w16 ? parity16 : parity8), 32'(^exp_s));
`endif
    @(posedge clk);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(cur_done(w16)), 32'd0);
    check({tag, " s_hold_after"}, 32'(cur_s(w16)), 32'(exp_s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          q_done[$];
    int          pulses;
    int          busy_seen;
    bit          w16_r;
    logic [2:0]  op_r;
    logic [15:0] a_r, b_r;

    vecs[0]  = '{1'b0, 3'd1, 16'h000F, 16'h00F0, 16'h00FF};
    vecs[1]  = '{1'b0, 3'd2, 16'h00AA, 16'h00FF, 16'h0055};
    vecs[2]  = '{1'b0, 3'd4, 16'h003C, 16'h003C, 16'h0000};
    vecs[3]  = '{1'b0, 3'd0, 16'h00F0, 16'h003C, 16'h0030};
    vecs[4]  = '{1'b0, 3'd5, 16'h000F, 16'h0033, 16'h00C3};
    vecs[5]  = '{1'b0, 3'd6, 16'h005A, 16'h0000, 16'h00A5};
    vecs[6]  = '{1'b0, 3'd3, 16'h000F, 16'h00F0, 16'h0000};
    vecs[7]  = '{1'b1, 3'd0, 16'h1234, 16'h00FF, 16'h0034};
    vecs[8]  = '{1'b1, 3'd1, 16'h1234, 16'h00FF, 16'h12FF};
    vecs[9]  = '{1'b1, 3'd2, 16'h1234, 16'h00FF, 16'hFFCB};
    vecs[10] = '{1'b1, 3'd3, 16'h1234, 16'h00FF, 16'hED00};
    vecs[11] = '{1'b1, 3'd4, 16'h1234, 16'h00FF, 16'h12CB};
    vecs[12] = '{1'b1, 3'd5, 16'h1234, 16'h00FF, 16'hED34};
    vecs[13] = '{1'b1, 3'd6, 16'h1234, 16'h00FF, 16'hEDCB};
    vecs[14] = '{1'b1, 3'd7, 16'h1234, 16'h00FF, 16'h1234};

    reset = 1'b1; start8 = 1'b0; start16 = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy8", 32'(busy8), 32'd0);
    check("reset done8", 32'(done8), 32'd0);
    check("reset s8", 32'(s8), 32'd0);
    check("reset busy16", 32'(busy16), 32'd0);
    check("reset s16", 32'(s16), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].w16, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_s,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      w16_r = 1'($urandom_range(0, 1));
      op_r  = 3'($urandom_range(0, 7));
      a_r   = 16'($urandom);
      b_r   = 16'($urandom);
      run_op(w16_r, op_r, a_r, b_r, ref_op(op_r, a_r, b_r, w16_r), $sformatf("rnd%0d", i));
    end

    // start held high: a new operation every WIDTH+2 cycles.
    @(negedge clk);
    start8 = 1'b1; op = 3'd0; a = 16'h00F0; b = 16'h003C;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        q_done.push_back(k);
        check("cont s", 32'(s8), 32'h30);
      end
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    check("cont pulse_count", 32'(q_done.size()), 32'd3);
    for (int i = 0; i < q_done.size(); i++)
      check($sformatf("cont pulse%0d_cycle", i), 32'(q_done[i]), 32'(9 + 10 * i));

    // Reset in the middle of RUN aborts silently and clears s.
    run_op(1'b0, 3'd7, 16'h00A5, 16'h0000, 16'h00A5, "pre_reset");
    @(negedge clk);
    start8 = 1'b1; op = 3'd3; a = 16'h0012; b = 16'h0034;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun busy8", 32'(busy8), 32'd0);
    check("midrun s8", 32'(s8), 32'd0);
    check("midrun done8", 32'(done8), 32'd0);
    check("midrun s16", 32'(s16), 32'd0);
    @(negedge clk);
    start8 = 1'b1; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start8 = 1'b0; start16 = 1'b0;
    #1;
    check("start_in_reset busy8", 32'(busy8), 32'd0);
    check("start_in_reset busy16", 32'(busy16), 32'd0);
    pulses = 0; busy_seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) pulses++;
      if (busy8) busy_seen++;
    end
    check("aborted done_pulses", 32'(pulses), 32'd0);
    check("aborted busy_cycles", 32'(busy_seen), 32'd0);
    run_op(1'b0, 3'd3, 16'h0012, 16'h0034, ref_op(3'd3, 16'h0012, 16'h0034, 1'b0), "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/nand_serial_lu.md
NAND_SERIAL_LU -- requirements
Module: nand_serial_lu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, an operation request sampled on a clk rising edge.
REQ-005 The block SHALL have port op, input, 3 bits, the operation select sampled with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each, the operands sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-009 The block SHALL have port s, output, WIDTH bits, the registered result.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE, start=1 SHALL latch a, b and op, clear the bit index to 0, and move to RUN on the same edge.
REQ-012 In RUN, the block SHALL evaluate exactly one bit per cycle, LSB first, writing result bit i into a shift or result register, and SHALL increment i.
REQ-013 After bit WIDTH-1 is evaluated, the FSM SHALL move to DONE.
REQ-014 Each bit SHALL be computed by a single 2-input NAND primitive function applied per the op encoding:
  - 0 AND
  - 1 OR
  - 2 NAND
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 NOT a
  - 7 pass a
REQ-015 In DONE, the block SHALL update s with the completed result, assert done for exactly one cycle, and return to IDLE.
REQ-016 Latency from the start edge to done=1 SHALL be WIDTH+1 cycles; the next start SHALL be accepted in the cycle after done.
REQ-017 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-018 start SHALL be ignored while busy=1, and latched operands SHALL NOT change mid-operation.
REQ-019 s SHALL hold its last value between completions; partial results SHALL NOT appear on s.
REQ-020 Changes to a, b or op while busy SHALL have no effect on the result.

Reset
REQ-021 reset=1 SHALL asynchronously force FSM=IDLE, bit index=0, s=0, busy=0, done=0, and flags=0 when present.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse; s SHALL read 0.
REQ-023 start SHALL NOT be accepted on any edge where reset=1.

Configuration
REQ-024 With macro NAND_LU_FLAGS_EN defined, the block SHALL add outputs zero (1 bit, s==0) and parity (1 bit, XOR of s), both registered and updated on the same edge as s.
REQ-025 Without NAND_LU_FLAGS_EN, zero and parity SHALL be absent from the port list, and all other behaviour SHALL be identical.

Verification
REQ-026 WIDTH=8, op=1, a=8'h0F, b=8'hF0, start for one cycle -> busy=1 for 9 cycles, done pulses at edge 9, s=8'hFF.
REQ-027 WIDTH=8, op=2, a=8'hAA, b=8'hFF -> s=8'h55; with NAND_LU_FLAGS_EN, zero=0 and parity=0.
REQ-028 op=4, a=b=8'h3C -> s=8'h00, zero=1 (flags build); then change a to 8'hFF mid-RUN -> s is still 8'h00.
REQ-029 start held high continuously with op=0, a=8'hF0, b=8'h3C -> one operation per 10 cycles, done pulses spaced 10 cycles apart, s=8'h30.
REQ-030 reset pulsed at cycle 4 of RUN -> busy=0 and s=0 immediately, no done pulse; a fresh start completes normally.
REQ-031 WIDTH=16, all 8 ops with a=16'h1234 and b=16'h00FF -> s matches the bitwise reference for each op, and latency is 17 cycles.
